// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit and the data memory.
// The LSU is the master; the memory (or a bench model of it) is the slave.
interface mem_stage_lsu_if #(
  parameter int n = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [n-1:0] mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ready;
  logic [n-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the MIPS 32-bit pipeline.
// Turns byte/half/word loads and stores into aligned big-endian 32-bit
// requests, holds the pipeline while a request is outstanding, and reports
// misaligned accesses and bus timeouts as one-cycle pulses.
module mem_stage_lsu #(
  parameter int n       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic           op_read,
  input  logic           op_write,
  input  logic [1:0]     op_size,
  input  logic           op_unsigned,
  input  logic [n-1:0]   op_addr,
  input  logic [n-1:0]   op_wdata,
  output logic           stall,
  output logic [n-1:0]   load_data,
  output logic           load_valid,
  output logic           misalign,
  output logic           bus_err,
  mem_stage_lsu_if.master mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [1:0]    lat_off;

  logic          access;
  logic          misaligned_op;
  logic [n-1:0]  fmt_wdata;
  logic [3:0]    fmt_be;
  logic [n-1:0]  ext_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  assign access = op_valid & (op_read | op_write);

  // Pipeline is held while an access is being launched and while it is in flight; never during reset.
  assign stall = ~reset & (((state == IDLE) & access) | (state == REQ));

  // Alignment rule: bytes always fit, halves need an even address, words need a multiple of four.
  always_comb begin
    misaligned_op = 1'b0;
    case (op_size)
      2'b00:   misaligned_op = 1'b0;
      2'b01:   misaligned_op = op_addr[0];
      default: misaligned_op = |op_addr[1:0];
    endcase
  end

  // Big-endian store lane formatting: replicate the data and enable only the addressed lanes.
  always_comb begin
    fmt_wdata = '0;
    fmt_be    = 4'b1111;
    if (op_write) begin
      case (op_size)
        2'b00: begin
          fmt_wdata = {4{op_wdata[7:0]}};
          fmt_be    = 4'b1000 >> op_addr[1:0];
        end
        2'b01: begin
          fmt_wdata = {2{op_wdata[15:0]}};
          fmt_be    = op_addr[1] ? 4'b0011 : 4'b1100;
        end
        default: begin
          fmt_wdata = op_wdata;
          fmt_be    = 4'b1111;
        end
      endcase
    end
  end

  // Pick the addressed byte/half out of the returned word and sign- or zero-extend it.
  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    ext_data = mem.mem_rdata;
    case (lat_off)
      2'd0:    sel_byte = mem.mem_rdata[31:24];
      2'd1:    sel_byte = mem.mem_rdata[23:16];
      2'd2:    sel_byte = mem.mem_rdata[15:8];
      default: sel_byte = mem.mem_rdata[7:0];
    endcase
    sel_half = lat_off[1] ? mem.mem_rdata[15:0] : mem.mem_rdata[31:16];
    case (lat_size)
      2'b00:   ext_data = {{(n-8){~lat_unsigned & sel_byte[7]}}, sel_byte};
      2'b01:   ext_data = {{(n-16){~lat_unsigned & sel_half[15]}}, sel_half};
      default: ext_data = mem.mem_rdata;
    endcase
  end

  // Access sequencer: launch from IDLE, wait for ready or timeout in REQ, report in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_size      <= 2'b00;
      lat_unsigned  <= 1'b0;
      lat_off       <= 2'b00;
      load_data     <= '0;
      load_valid    <= 1'b0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= 4'b0000;
    end else begin
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned_op) begin
              state    <= DONE;
              misalign <= 1'b1;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              lat_size      <= op_size;
              lat_unsigned  <= op_unsigned;
              lat_off       <= op_addr[1:0];
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= op_write;
              mem.mem_addr  <= {op_addr[n-1:2], 2'b00};
              mem.mem_wdata <= fmt_wdata;
              mem.mem_be    <= fmt_be;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) begin
              load_data  <= ext_data;
              load_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            bus_err     <= 1'b1;
            if (!mem.mem_we) begin
              load_data  <= '0;
              load_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, random accesses against a
// behavioural model, and reset-in-flight / power-on reset sequences.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic        we;
    logic        both;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        never;
  } acc_t;

  typedef struct {
    int          stall;
    int          req;
    int          mis;
    int          err;
    int          lv;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] load;
  } exp_t;

  typedef struct {
    int          stall_cycles;
    int          req_cycles;
    int          mis_count;
    int          err_count;
    int          lv_count;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stable;
    logic [31:0] load_data;
    logic        timed_out;
  } obs_t;

  typedef struct {
    acc_t a;
    exp_t e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_read;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;

  int compared;
  int mismatched;
  logic [31:0] model_ld;
  vec_t vecs[$];
  acc_t ra;
  exp_t re;
  obs_t ro;
  int req_seen;

  mem_stage_lsu_if #(.n(32)) bus ();

  mem_stage_lsu #(.n(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_read     (op_read),
    .op_write    (op_write),
    .op_size     (op_size),
    .op_unsigned (op_unsigned),
    .op_addr     (op_addr),
    .op_wdata    (op_wdata),
    .stall       (stall),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .mem         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk_vec(input logic we, input logic both, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int delay, input logic never,
                                  input int stall_c, input int req_c, input int mis, input int err, input int lv,
                                  input logic [31:0] eaddr, input logic [31:0] ewdata, input logic [3:0] ebe,
                                  input logic [31:0] eload);
    vec_t v;
    v.a.we = we; v.a.both = both; v.a.size = size; v.a.uns = uns;
    v.a.addr = addr; v.a.wdata = wdata; v.a.rdata = rdata;
    v.a.delay = delay; v.a.never = never;
    v.e.stall = stall_c; v.e.req = req_c; v.e.mis = mis; v.e.err = err; v.e.lv = lv;
    v.e.we = we; v.e.addr = eaddr; v.e.wdata = ewdata; v.e.be = ebe; v.e.load = eload;
    return v;
  endfunction

  // Reference: access outcome computed from the byte-lane rules with plain arithmetic.
  function automatic exp_t model_access(input acc_t a, input logic [31:0] prev_ld);
    exp_t e;
    int bytes;
    int off;
    int shift;
    logic [31:0] v;
    logic [31:0] span;
    e = '{default: 0};
    bytes = (a.size == 2'd0) ? 1 : (a.size == 2'd1) ? 2 : 4;
    off   = int'(a.addr[1:0]);
    e.load = prev_ld;
    e.we   = a.we;
    if ((off % bytes) != 0) begin
      e.mis   = 1;
      e.stall = 1;
      return e;
    end
    e.req   = a.never ? TIMEOUT : a.delay + 1;
    e.stall = 1 + e.req;
    e.err   = a.never ? 1 : 0;
    e.addr  = a.addr - 32'(off);
    if (a.we) begin
      if (bytes == 1) begin
        e.be    = 4'(8 >> off);
        e.wdata = (a.wdata & 32'hFF) * 32'h0101_0101;
      end else if (bytes == 2) begin
        e.be    = (off == 0) ? 4'hC : 4'h3;
        e.wdata = (a.wdata & 32'hFFFF) * 32'h0001_0001;
      end else begin
        e.be    = 4'hF;
        e.wdata = a.wdata;
      end
    end else begin
      e.be    = 4'hF;
      e.wdata = 32'h0;
      e.lv    = 1;
      if (a.never) begin
        e.load = 32'h0;
      end else begin
        shift = 8 * (4 - bytes - off);
        v = a.rdata >> shift;
        if (bytes < 4) begin
          span = 32'h1 << (8 * bytes);
          v = v & (span - 32'h1);
          if (!a.uns && (v >= (span >> 1))) v = v - span;
        end
        e.load = v;
      end
    end
    return e;
  endfunction

  task automatic countFlags(inout obs_t o);
    if (load_valid) o.lv_count++;
    if (misalign)   o.mis_count++;
    if (bus_err)    o.err_count++;
  endtask

  // Present one op, act as the memory (ready after 'delay' REQ cycles), record what the DUT did.
  task automatic applyStimulus(input acc_t a, output obs_t o);
    bit seen_stall;
    bit finished;
    o = '{default: 0};
    o.stable = 1'b1;
    seen_stall = 0;
    finished = 0;
    @(negedge clk);
    op_valid    = 1'b1;
    op_write    = a.we;
    op_read     = ~a.we | a.both;
    op_size     = a.size;
    op_unsigned = a.uns;
    op_addr     = a.addr;
    op_wdata    = a.wdata;
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.mem_req) begin
        if (o.req_cycles == 0) begin
          o.we = bus.mem_we; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata; o.be = bus.mem_be;
        end else if (o.we !== bus.mem_we || o.addr !== bus.mem_addr ||
                     o.wdata !== bus.mem_wdata || o.be !== bus.mem_be) begin
          o.stable = 1'b0;
        end
        bus.mem_ready = !a.never && (o.req_cycles >= a.delay);
        bus.mem_rdata = bus.mem_ready ? a.rdata : $urandom;
        o.req_cycles++;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      #1;
      if (stall) begin
        o.stall_cycles++;
        seen_stall = 1;
      end else if (seen_stall) begin
        finished = 1;
      end
      countFlags(o);
    end
    o.timed_out = !finished;
    @(negedge clk);
    op_valid = 1'b0;
    op_read  = 1'b0;
    op_write = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    if (stall) o.stall_cycles++;
    if (bus.mem_req) o.req_cycles++;
    countFlags(o);
    o.load_data = load_data;
  endtask

  task automatic checkAccess(input string tag, input obs_t o, input exp_t e);
    checkOutput({tag, " completed"}, o.timed_out, 0);
    checkOutput({tag, " stall cycles"}, o.stall_cycles, e.stall);
    checkOutput({tag, " req cycles"}, o.req_cycles, e.req);
    checkOutput({tag, " misalign pulses"}, o.mis_count, e.mis);
    checkOutput({tag, " bus_err pulses"}, o.err_count, e.err);
    checkOutput({tag, " load_valid pulses"}, o.lv_count, e.lv);
    checkOutput({tag, " load_data"}, o.load_data, e.load);
    if (e.req > 0) begin
      checkOutput({tag, " mem_addr"}, o.addr, e.addr);
      checkOutput({tag, " mem_we"}, o.we, e.we);
      checkOutput({tag, " mem_wdata"}, o.wdata, e.wdata);
      checkOutput({tag, " mem_be"}, o.be, e.be);
      checkOutput({tag, " mem stable"}, o.stable, 1);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;

    // we both sz uns addr wdata rdata dly never | stall req mis err lv eaddr ewdata ebe eload
    vecs.push_back(mk_vec(0,0,2'd2,0,32'h104,32'h0,32'hDEADBEEF,0,0, 2,1,0,0,1,32'h104,32'h0,4'hF,32'hDEADBEEF));
    vecs.push_back(mk_vec(0,0,2'd0,0,32'h103,32'h0,32'h112233F0,0,0, 2,1,0,0,1,32'h100,32'h0,4'hF,32'hFFFFFFF0));
    vecs.push_back(mk_vec(0,0,2'd0,1,32'h103,32'h0,32'h112233F0,0,0, 2,1,0,0,1,32'h100,32'h0,4'hF,32'h000000F0));
    vecs.push_back(mk_vec(1,0,2'd1,0,32'h202,32'h0000ABCD,32'h0,3,0, 5,4,0,0,0,32'h200,32'hABCDABCD,4'h3,32'h000000F0));
    vecs.push_back(mk_vec(0,0,2'd2,0,32'h106,32'h0,32'h0,0,0, 1,0,1,0,0,32'h0,32'h0,4'h0,32'h000000F0));
    vecs.push_back(mk_vec(0,0,2'd2,0,32'h300,32'h0,32'h0,0,1, 17,16,0,1,1,32'h300,32'h0,4'hF,32'h0));
    vecs.push_back(mk_vec(1,0,2'd0,0,32'h401,32'hFFFFFF55,32'h0,1,0, 3,2,0,0,0,32'h400,32'h55555555,4'h4,32'h0));
    vecs.push_back(mk_vec(0,0,2'd1,0,32'h010,32'h0,32'h80011234,0,0, 2,1,0,0,1,32'h010,32'h0,4'hF,32'hFFFF8001));
    vecs.push_back(mk_vec(0,0,2'd1,1,32'h012,32'h0,32'h8001F234,2,0, 4,3,0,0,1,32'h010,32'h0,4'hF,32'h0000F234));
    vecs.push_back(mk_vec(0,0,2'd1,0,32'h011,32'h0,32'h0,0,0, 1,0,1,0,0,32'h0,32'h0,4'h0,32'h0000F234));
    vecs.push_back(mk_vec(1,0,2'd3,0,32'h020,32'h12345678,32'h0,0,0, 2,1,0,0,0,32'h020,32'h12345678,4'hF,32'h0000F234));
    vecs.push_back(mk_vec(1,1,2'd2,0,32'h024,32'hCAFEF00D,32'h0,0,0, 2,1,0,0,0,32'h024,32'hCAFEF00D,4'hF,32'h0000F234));
    vecs.push_back(mk_vec(0,0,2'd0,0,32'h000,32'h0,32'h7F000000,0,0, 2,1,0,0,1,32'h000,32'h0,4'hF,32'h0000007F));
    vecs.push_back(mk_vec(0,0,2'd3,0,32'h032,32'h0,32'h0,0,0, 1,0,1,0,0,32'h0,32'h0,4'h0,32'h0000007F));
    vecs.push_back(mk_vec(1,0,2'd0,0,32'h503,32'h000000A5,32'h0,0,1, 17,16,0,1,0,32'h500,32'hA5A5A5A5,4'h1,32'h0000007F));

    // Power-on reset with an access already presented: nothing may stall or request.
    reset = 1'b1;
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_size = 2'd2; op_unsigned = 1'b0;
    op_addr = 32'h0; op_wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset stall", stall, 0);
    checkOutput("reset mem_req", bus.mem_req, 0);
    checkOutput("reset mem_be", bus.mem_be, 0);
    checkOutput("reset load_data", load_data, 0);
    checkOutput("reset load_valid", load_valid, 0);
    checkOutput("reset misalign", misalign, 0);
    checkOutput("reset bus_err", bus_err, 0);
    op_valid = 1'b0; op_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released, running %0d table vectors", vecs.size());

    model_ld = 32'h0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, ro);
      checkAccess($sformatf("vec%0d", i), ro, vecs[i].e);
      model_ld = vecs[i].e.load;
    end

    $display("[TB] random accesses against reference model");
    for (int i = 0; i < 40; i++) begin
      ra.we    = 1'($urandom_range(0, 1));
      ra.both  = ra.we & ($urandom_range(0, 3) == 0);
      ra.size  = 2'($urandom_range(0, 3));
      ra.uns   = 1'($urandom_range(0, 1));
      ra.addr  = $urandom & 32'h0000_0FFF;
      ra.wdata = $urandom;
      ra.rdata = $urandom;
      ra.delay = $urandom_range(0, 4);
      ra.never = ($urandom_range(0, 9) == 0);
      re = model_access(ra, model_ld);
      applyStimulus(ra, ro);
      checkAccess($sformatf("rand%0d", i), ro, re);
      model_ld = re.load;
    end

    // Reset in the middle of an outstanding request, off the clock edge.
    @(negedge clk);
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_size = 2'd2; op_unsigned = 1'b0;
    op_addr = 32'h40; op_wdata = 32'h0;
    bus.mem_ready = 1'b0;
    req_seen = 0;
    for (int c = 0; c < 10 && req_seen < 3; c++) begin
      @(negedge clk);
      if (bus.mem_req) req_seen++;
    end
    checkOutput("midreq req cycles before reset", req_seen, 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreq mem_req", bus.mem_req, 0);
    checkOutput("midreq stall", stall, 0);
    checkOutput("midreq mem_addr", bus.mem_addr, 0);
    checkOutput("midreq mem_be", bus.mem_be, 0);
    checkOutput("midreq load_data", load_data, 0);
    checkOutput("midreq load_valid", load_valid, 0);
    op_valid = 1'b0; op_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(vecs[0].a, ro);
    checkAccess("post-reset", ro, vecs[0].e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Initiator side of the data-memory interface for the MIPS 32-bit pipeline.
- Sits in the MEM stage, between the EX/MEM pipeline register and the data memory.
- Converts byte, halfword and word loads/stores into aligned 32-bit big-endian memory requests with a valid/ready handshake.
- Stalls the pipeline until each access completes, and flags misaligned accesses and bus timeouts.

Parameters:
- n, 32, data and address width.
- TIMEOUT, 16, number of REQ cycles without mem_ready before the access is aborted with bus_err.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  a memory operation is present in EX/MEM.
- op_read  input  1  load.
- op_write  input  1  store; has priority over op_read when both are set.
- op_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- op_unsigned  input  1  zero-extend loads (lbu/lhu); otherwise sign-extend.
- op_addr  input  n  byte address.
- op_wdata  input  n  store data, right-justified.
- stall  output  1  freezes pipeline registers upstream of MEM.
- load_data  output  n  extended load result; held until the next completed load.
- load_valid  output  1  one-cycle pulse when load_data is updated.
- misalign  output  1  one-cycle pulse for a misaligned access.
- bus_err  output  1  one-cycle pulse on timeout.
- mem_req  output  1  request valid to data memory.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  n  word-aligned address: {op_addr[31:2], 2'b00}.
- mem_wdata  output  n  replicated store data.
- mem_be  output  4  byte enables; bit 3 = byte at offset 0 (bits 31:24).
- mem_ready  input  1  memory accepts or completes the request this cycle.
- mem_rdata  input  n  read data, valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All registered outputs go to 0.
  - stall is forced to 0 while reset is high.
  - An in-flight request is dropped immediately; there is no write-back.
- States: IDLE, REQ, DONE.
- IDLE:
  - An access is op_valid & (op_read | op_write).
  - An access is misaligned when: half with addr[0]=1, or word/11 with addr[1:0]≠00. Bytes are never misaligned.
  - Aligned access: stall=1 combinationally. Latch addr, size, unsigned, we and offset. Drive mem_addr, mem_we, mem_wdata, mem_be, and mem_req=1 from the next edge. Next state is REQ.
  - Misaligned access: stall=1 for this cycle, no memory request, next state DONE with misalign=1.
  - No access: stall=0, remain in IDLE.
- REQ:
  - stall=1 and mem_req=1; all mem_* outputs stay stable.
  - A timeout counter increments each cycle and clears on entry.
  - If mem_ready=1: drop mem_req at the next edge and go to DONE. For a load, register the extracted and extended result into load_data and pulse load_valid=1 in DONE.
  - If mem_ready=0 and the counter reaches TIMEOUT-1: drop mem_req, go to DONE with bus_err=1. For a load, load_data=0 with load_valid=1.
- DONE:
  - stall=0 and op inputs are ignored, because they still hold the completed op.
  - Flag pulses are visible this cycle only.
  - Next state is IDLE.
  - Minimum access is 3 cycles (IDLE→REQ→DONE) when mem_ready=1 on the first REQ cycle.
- Store formatting (big-endian):
  - Byte: wdata={4{op_wdata[7:0]}}; be by offset: 0→1000, 1→0100, 2→0010, 3→0001.
  - Half: wdata={2{op_wdata[15:0]}}; be by offset: 0→1100, 2→0011.
  - Word: wdata=op_wdata, be=1111.
  - Reads drive be=1111 and wdata=0.
- Load extraction:
  - Byte k = mem_rdata[31-8k -: 8].
  - Half at offset 0 = [31:16]; at offset 2 = [15:0].
  - Extend to 32 bits using op_unsigned.
- Stores never touch load_data or load_valid.

Test Plan:
- Word load at 0x104, mem_ready on the first REQ cycle, mem_rdata=0xDEADBEEF: mem_addr=0x104, be=1111; stall high 2 cycles; load_data=0xDEADBEEF with a 1-cycle load_valid.
- Signed byte load at 0x103, mem_rdata=0x112233F0: load_data=0xFFFFFFF0. Same access with op_unsigned=1: load_data=0x000000F0.
- Half store 0x0000ABCD at 0x202: mem_addr=0x200, mem_wdata=0xABCDABCD, be=0011, mem_we=1; mem_ready delayed 3 cycles keeps mem_req and stall high throughout.
- Word load at 0x106: misalign pulse, no mem_req, stall high exactly 1 cycle, load_valid=0.
- mem_ready held 0 with TIMEOUT=16: mem_req drops after 16 REQ cycles, bus_err pulses, load_data=0.
- reset asserted mid-REQ: mem_req, stall and all outputs go to 0 without waiting for clk; after release, the next op starts cleanly from IDLE.
